// File: rtl/itlb_micro_cache_pkg.sv
// Shared types and constants for the micro TLB: exception kinds, segment decode, entry layout.
package itlb_micro_cache_pkg;

  localparam int unsigned VPN_W  = 20;
  localparam int unsigned VPN2_W = 19;
  localparam int unsigned PFN_W  = 20;
  localparam int unsigned CA_W   = 3;

  typedef enum logic [1:0] {
    TLBK_NONE     = 2'd0,
    TLBK_REFILL   = 2'd1,
    TLBK_INVALID  = 2'd2,
    TLBK_MODIFIED = 2'd3
  } tlbk_e;

  localparam logic [CA_W-1:0] CA_CACHEABLE = 3'd3;

  // vpn[19:18] == 2'b10 selects kseg0/kseg1; vpn[17] then picks kseg1
  localparam logic [1:0] SEG_UNMAPPED = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } refill_state_e;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic              found;
    logic [PFN_W-1:0]  pfn0;
    logic [PFN_W-1:0]  pfn1;
    logic [CA_W-1:0]   c0;
    logic [CA_W-1:0]   c1;
    logic              d0;
    logic              d1;
    logic              v0;
    logic              v1;
  } utlb_entry_t;

  function automatic logic [PFN_W-1:0] unmapped_pfn(input logic [VPN_W-1:0] vpn);
    if (vpn[17]) return {3'b000, vpn[16:0]};
    else         return {1'b0, vpn[18:0]};
  endfunction

endpackage

// File: rtl/itlb_micro_cache_entry_match.sv
// Associative compare of all buffer entries against one VPN2, plus lowest free slot search.
module utlb_entry_match
  import itlb_micro_cache_pkg::*;
#(
  parameter int unsigned ENTRIES = 4,
  localparam int unsigned IDX_W = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]             entry_valid,
  input  logic [ENTRIES-1:0][VPN2_W-1:0] entry_vpn2,
  input  logic [VPN2_W-1:0]              vpn2,
  output logic [ENTRIES-1:0]             hit,
  output logic                           any_invalid,
  output logic [IDX_W-1:0]               lowest_invalid
);

  always_comb begin
    hit            = '0;
    any_invalid    = 1'b0;
    lowest_invalid = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      hit[i] = entry_valid[i] && (entry_vpn2[i] == vpn2);
      if (!entry_valid[i] && !any_invalid) begin
        any_invalid    = 1'b1;
        lowest_invalid = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/itlb_micro_cache.sv
// Micro translation buffer: combinational lookup over ENTRIES page pairs, refilled from the
// main TLB one entry at a time through a two-state req/ack FSM.
module itlb_micro_cache
  import itlb_micro_cache_pkg::*;
#(
  parameter int unsigned ENTRIES   = 4,
  parameter bit          MODE_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [VPN_W-1:0]  lookup_vpn,
  input  logic              lookup_store,
  output logic [PFN_W-1:0]  lookup_pfn,
  output logic              lookup_cached,
  output logic              tlb_ex,
  output logic [1:0]        tlb_exkind,
  output logic              stall,
  output logic              refill_req,
  output logic [VPN2_W-1:0] refill_vpn2,
  input  logic              refill_ack,
  input  logic              refill_found,
  input  logic [PFN_W-1:0]  refill_pfn0,
  input  logic [PFN_W-1:0]  refill_pfn1,
  input  logic [CA_W-1:0]   refill_c0,
  input  logic [CA_W-1:0]   refill_c1,
  input  logic              refill_d0,
  input  logic              refill_d1,
  input  logic              refill_v0,
  input  logic              refill_v1,
  input  logic              flush
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  utlb_entry_t                    ent_q [ENTRIES];
  logic [ENTRIES-1:0]             valid_q;
  logic [IDX_W-1:0]               rr_q;
  refill_state_e                  state_q, state_d;
  logic [VPN2_W-1:0]              refill_vpn2_q;

  logic [ENTRIES-1:0][VPN2_W-1:0] ent_vpn2;
  logic [ENTRIES-1:0]             hit;
  logic                           any_hit;
  logic                           any_invalid;
  logic [IDX_W-1:0]               lowest_invalid;
  logic [IDX_W-1:0]               victim;
  logic                           fill;
  logic                           unmapped;
  utlb_entry_t                    sel;
  utlb_entry_t                    new_ent;
  tlbk_e                          kind;

  always_comb begin
    for (int unsigned i = 0; i < ENTRIES; i++) ent_vpn2[i] = ent_q[i].vpn2;
  end

  utlb_entry_match #(.ENTRIES(ENTRIES)) u_match (
    .entry_valid    (valid_q),
    .entry_vpn2     (ent_vpn2),
    .vpn2           (lookup_vpn[VPN_W-1:1]),
    .hit            (hit),
    .any_invalid    (any_invalid),
    .lowest_invalid (lowest_invalid)
  );

  assign any_hit  = |hit;
  assign unmapped = (lookup_vpn[VPN_W-1:VPN_W-2] == SEG_UNMAPPED);
  assign stall    = lookup_valid && !unmapped && !any_hit;

  // Hit vector is one-hot, so an OR-reduction selects the matching entry
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (hit[i]) sel = sel | ent_q[i];
    end
  end

  always_comb begin
    lookup_pfn    = '0;
    lookup_cached = 1'b0;
    kind          = TLBK_NONE;
    if (unmapped) begin
      lookup_pfn    = unmapped_pfn(lookup_vpn);
      lookup_cached = !lookup_vpn[17];
    end else if (any_hit) begin
      lookup_pfn    = lookup_vpn[0] ? sel.pfn1 : sel.pfn0;
      lookup_cached = (lookup_vpn[0] ? sel.c1 : sel.c0) == CA_CACHEABLE;
      if (lookup_valid) begin
        if (!sel.found)
          kind = TLBK_REFILL;
        else if (!(lookup_vpn[0] ? sel.v1 : sel.v0))
          kind = TLBK_INVALID;
        else if (MODE_DATA && lookup_store && !(lookup_vpn[0] ? sel.d1 : sel.d0))
          kind = TLBK_MODIFIED;
      end
    end
  end

  assign tlb_exkind = kind;
  assign tlb_ex     = (kind != TLBK_NONE);

  // Refill FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (stall) state_d = ST_REQ;
      ST_REQ:  if (refill_ack) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_comb begin
    refill_req = (state_q == ST_REQ);
  end

  assign refill_vpn2 = refill_vpn2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      refill_vpn2_q <= '0;
    else if (state_q == ST_IDLE && state_d == ST_REQ)
      refill_vpn2_q <= lookup_vpn[VPN_W-1:1];
  end

  // A flush in the ack cycle discards the response
  assign fill   = (state_q == ST_REQ) && refill_ack && !flush;
  assign victim = any_invalid ? lowest_invalid : rr_q;

  always_comb begin
    new_ent.vpn2  = refill_vpn2_q;
    new_ent.found = refill_found;
    new_ent.pfn0  = refill_pfn0;
    new_ent.pfn1  = refill_pfn1;
    new_ent.c0    = refill_c0;
    new_ent.c1    = refill_c1;
    new_ent.d0    = refill_d0;
    new_ent.d1    = refill_d1;
    new_ent.v0    = refill_v0;
    new_ent.v1    = refill_v1;
  end

  always_ff @(posedge clk) begin
    if (fill) ent_q[victim] <= new_ent;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (flush) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (fill) begin
      valid_q[victim] <= 1'b1;
      if (!any_invalid) rr_q <= IDX_W'(rr_q + IDX_W'(1));
    end
  end

endmodule

// File: tb/tb_itlb_micro_cache.sv
// Directed scoreboard bench for itlb_micro_cache (ENTRIES=4, data side).
module tb_itlb_micro_cache;
  import itlb_micro_cache_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        lookup_valid, lookup_store;
  logic [19:0] lookup_vpn;
  logic [19:0] lookup_pfn;
  logic        lookup_cached, tlb_ex, stall, refill_req;
  logic [1:0]  tlb_exkind;
  logic [18:0] refill_vpn2;
  logic        refill_ack, refill_found, refill_d0, refill_d1, refill_v0, refill_v1, flush;
  logic [19:0] refill_pfn0, refill_pfn1;
  logic [2:0]  refill_c0, refill_c1;

  always #5 clk = ~clk;

  itlb_micro_cache #(.ENTRIES(4), .MODE_DATA(1'b1)) dut (
    .clk(clk), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_vpn(lookup_vpn), .lookup_store(lookup_store),
    .lookup_pfn(lookup_pfn), .lookup_cached(lookup_cached), .tlb_ex(tlb_ex),
    .tlb_exkind(tlb_exkind), .stall(stall), .refill_req(refill_req),
    .refill_vpn2(refill_vpn2), .refill_ack(refill_ack), .refill_found(refill_found),
    .refill_pfn0(refill_pfn0), .refill_pfn1(refill_pfn1),
    .refill_c0(refill_c0), .refill_c1(refill_c1),
    .refill_d0(refill_d0), .refill_d1(refill_d1),
    .refill_v0(refill_v0), .refill_v1(refill_v1), .flush(flush)
  );

  typedef struct {
    string       name;
    bit          cl;
    logic        stall;
    logic [1:0]  kind;
    bit          cp;
    logic [19:0] pfn;
    logic        cached;
    bit          cr;
    logic        req;
    bit          cv;
    logic [18:0] vpn2;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check1(string n, string f, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s got=%0h want=%0h", n, f, act, want);
    end
  endtask

  // Monitor: drain every pending expectation against the outputs at the falling edge
  always @(negedge clk) begin
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.cl) begin
        check1(e.name, "stall", 32'(stall), 32'(e.stall));
        check1(e.name, "tlb_ex", 32'(tlb_ex), 32'(e.kind != 2'd0));
        check1(e.name, "exkind", 32'(tlb_exkind), 32'(e.kind));
      end
      if (e.cp) begin
        check1(e.name, "pfn", 32'(lookup_pfn), 32'(e.pfn));
        check1(e.name, "cached", 32'(lookup_cached), 32'(e.cached));
      end
      if (e.cr) check1(e.name, "refill_req", 32'(refill_req), 32'(e.req));
      if (e.cv) check1(e.name, "refill_vpn2", 32'(refill_vpn2), 32'(e.vpn2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(logic [19:0] v, logic st);
    lookup_valid = 1'b1; lookup_vpn = v; lookup_store = st;
  endtask

  task automatic idle_in();
    lookup_valid = 1'b0; lookup_vpn = '0; lookup_store = 1'b0;
  endtask

  task automatic exp_look(string n, logic s, logic [1:0] k, bit cp, logic [19:0] p, logic c);
    exp_t e;
    e.name = n; e.cl = 1'b1; e.stall = s; e.kind = k; e.cp = cp; e.pfn = p; e.cached = c;
    e.cr = 1'b0; e.req = 1'b0; e.cv = 1'b0; e.vpn2 = '0;
    q.push_back(e);
  endtask

  task automatic exp_req(string n, logic r, bit cv, logic [18:0] v);
    exp_t e;
    e.name = n; e.cl = 1'b0; e.stall = 1'b0; e.kind = 2'd0; e.cp = 1'b0; e.pfn = '0;
    e.cached = 1'b0; e.cr = 1'b1; e.req = r; e.cv = cv; e.vpn2 = v;
    q.push_back(e);
  endtask

  task automatic set_ack(logic fnd, logic [19:0] p0, logic [19:0] p1, logic [2:0] c0,
                         logic [2:0] c1, logic d0, logic d1, logic v0, logic v1);
    refill_ack = 1'b1; refill_found = fnd; refill_pfn0 = p0; refill_pfn1 = p1;
    refill_c0 = c0; refill_c1 = c1; refill_d0 = d0; refill_d1 = d1;
    refill_v0 = v0; refill_v1 = v1;
  endtask

  task automatic clr_ack();
    refill_ack = 1'b0; refill_found = 1'b0; refill_pfn0 = '0; refill_pfn1 = '0;
    refill_c0 = '0; refill_c1 = '0; refill_d0 = 1'b0; refill_d1 = 1'b0;
    refill_v0 = 1'b0; refill_v1 = 1'b0;
  endtask

  // Miss, then ack on the first REQ cycle: stall for exactly two cycles
  task automatic do_fill(string n, logic [19:0] v, logic fnd, logic [19:0] p0, logic [19:0] p1,
                         logic [2:0] c0, logic [2:0] c1, logic d0, logic d1, logic v0, logic v1);
    look(v, 1'b0);
    exp_look({n, "_miss"}, 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
    exp_req({n, "_idle"}, 1'b0, 1'b0, '0);
    step();
    set_ack(fnd, p0, p1, c0, c1, d0, d1, v0, v1);
    exp_look({n, "_stall2"}, 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
    exp_req({n, "_req"}, 1'b1, 1'b1, v[19:1]);
    step();
    clr_ack();
  endtask

  task automatic do_flush();
    idle_in(); flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    idle_in(); clr_ack();
    step();
    look(20'h00403, 1'b0);
    exp_look("rst_stall", 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
    exp_req("rst_req", 1'b0, 1'b1, 19'h0);
    step();
    reset = 1'b0;

    // Unmapped segments
    look(20'h80001, 1'b0); exp_look("kseg0", 1'b0, TLBK_NONE, 1'b1, 20'h00001, 1'b1); step();
    look(20'hA0002, 1'b1); exp_look("kseg1", 1'b0, TLBK_NONE, 1'b1, 20'h00002, 1'b0); step();
    look(20'h9FFFF, 1'b0); exp_look("kseg0_top", 1'b0, TLBK_NONE, 1'b1, 20'h1FFFF, 1'b1); step();
    look(20'hBFFFF, 1'b0); exp_look("kseg1_top", 1'b0, TLBK_NONE, 1'b1, 20'h1FFFF, 1'b0); step();

    // Miss with ack delayed five REQ cycles
    look(20'h00403, 1'b0);
    exp_look("dly_miss", 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
    exp_req("dly_idle", 1'b0, 1'b1, 19'h0);
    step();
    for (int k = 0; k < 5; k++) begin
      exp_look("dly_wait", 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
      exp_req("dly_req", 1'b1, 1'b1, 19'h00201);
      step();
    end
    set_ack(1'b1, 20'h11111, 20'h12345, 3'd2, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    exp_req("dly_ackcyc", 1'b1, 1'b1, 19'h00201);
    step();
    clr_ack();
    exp_look("dly_hit", 1'b0, TLBK_NONE, 1'b1, 20'h12345, 1'b1);
    exp_req("dly_done", 1'b0, 1'b0, '0);
    step();
    look(20'h00403, 1'b1); exp_look("mod_store", 1'b0, TLBK_MODIFIED, 1'b1, 20'h12345, 1'b1); step();
    look(20'h00402, 1'b0); exp_look("even_load", 1'b0, TLBK_NONE, 1'b1, 20'h11111, 1'b0); step();
    look(20'h00402, 1'b1); exp_look("even_store", 1'b0, TLBK_NONE, 1'b1, 20'h11111, 1'b0); step();
    look(20'h00403, 1'b0); exp_look("mod_load", 1'b0, TLBK_NONE, 1'b1, 20'h12345, 1'b1); step();

    // Not-found and invalid pages
    do_fill("nf", 20'h00800, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_look("nf_refill", 1'b0, TLBK_REFILL, 1'b0, '0, 1'b0); step();
    look(20'h00801, 1'b1); exp_look("nf_odd", 1'b0, TLBK_REFILL, 1'b0, '0, 1'b0); step();
    do_fill("inv", 20'h00C00, 1'b1, 20'h22222, 20'h33333, 3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_look("inv_even", 1'b0, TLBK_INVALID, 1'b0, '0, 1'b0); step();
    look(20'h00C01, 1'b1); exp_look("inv_odd_ok", 1'b0, TLBK_NONE, 1'b1, 20'h33333, 1'b1); step();

    // Flush and ack in the same REQ cycle
    look(20'h01000, 1'b0);
    exp_look("fa_miss", 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
    step();
    set_ack(1'b1, 20'hBBBBB, 20'h0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    exp_req("fa_req", 1'b1, 1'b1, 19'h00800);
    step();
    clr_ack(); flush = 1'b0;
    exp_look("fa_nowrite", 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
    exp_req("fa_idle", 1'b0, 1'b0, '0);
    step();
    idle_in();
    exp_req("fa_rereq", 1'b1, 1'b1, 19'h00800);
    set_ack(1'b1, 20'hAAAAA, 20'h0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    clr_ack();
    look(20'h01000, 1'b0); exp_look("latched_fill", 1'b0, TLBK_NONE, 1'b1, 20'hAAAAA, 1'b1); step();

    // Ack while IDLE must not write anything
    idle_in();
    set_ack(1'b1, 20'h55555, 20'h0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    clr_ack();
    look(20'h01000, 1'b0); exp_look("idle_ack", 1'b0, TLBK_NONE, 1'b1, 20'hAAAAA, 1'b1); step();
    do_fill("post_flush", 20'h00403, 1'b1, 20'h0, 20'h44444, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1);

    // Round-robin replacement with all four entries in use
    do_flush();
    for (int i = 0; i < 5; i++)
      do_fill("rr_fill", 20'(2 * i), 1'b1, 20'(32'h100 + i), '0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    look(20'h00008, 1'b0); exp_look("rr_v4", 1'b0, TLBK_NONE, 1'b1, 20'h00104, 1'b1); step();
    look(20'h00002, 1'b0); exp_look("rr_v1", 1'b0, TLBK_NONE, 1'b1, 20'h00101, 1'b1); step();
    look(20'h00006, 1'b0); exp_look("rr_v3", 1'b0, TLBK_NONE, 1'b1, 20'h00103, 1'b1); step();
    do_fill("rr_v0", 20'h00000, 1'b1, 20'h00200, '0, 3'd3, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    look(20'h00000, 1'b0); exp_look("rr_v0_hit", 1'b0, TLBK_NONE, 1'b1, 20'h00200, 1'b1); step();
    look(20'h00008, 1'b0); exp_look("rr_v4_kept", 1'b0, TLBK_NONE, 1'b1, 20'h00104, 1'b1); step();
    look(20'h00004, 1'b0); exp_look("rr_v2_kept", 1'b0, TLBK_NONE, 1'b1, 20'h00102, 1'b1); step();
    look(20'h00002, 1'b0); exp_look("rr_v1_gone", 1'b1, TLBK_NONE, 1'b0, '0, 1'b0); step();

    // Reset asserted while requesting
    idle_in();
    exp_req("rst_pre", 1'b1, 1'b1, 19'h00001);
    step();
    reset = 1'b1;
    exp_req("rst_async", 1'b0, 1'b1, 19'h0);
    step();
    reset = 1'b0;
    look(20'h00008, 1'b0);
    exp_look("rst_empty", 1'b1, TLBK_NONE, 1'b0, '0, 1'b0);
    exp_req("rst_idle", 1'b0, 1'b0, '0);
    step();
    idle_in();
    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
